// File: rtl/piso_serializer_if.sv
// Load/serial bus of the PISO serializer: load handshake in, serial bit stream out.
// No storage; every signal is a plain wire between producer and serializer.
// Backpressure is carried by load_ready (driven by the serializer, the slave side).
//
// Signals:
//   preset      master->slave  synchronous abort, forces serializer to idle
//   load_valid  master->slave  load_data holds a word to send
//   load_data   master->slave  WIDTH-bit parallel word
//   load_ready  slave->master  serializer can take a word this cycle
//   ser_out     slave->master  serial data bit
//   ser_valid   slave->master  ser_out carries a frame bit
//   done        slave->master  last bit of a frame is on ser_out
//   busy        slave->master  serializer is shifting a frame
interface piso_serializer_if #(
    parameter int WIDTH = 4
);
    logic             preset;
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_data;
    logic             ser_out;
    logic             ser_valid;
    logic             done;
    logic             busy;

    modport master (
        output preset,
        output load_valid,
        output load_data,
        input  load_ready,
        input  ser_out,
        input  ser_valid,
        input  done,
        input  busy
    );

    modport slave (
        input  preset,
        input  load_valid,
        input  load_data,
        output load_ready,
        output ser_out,
        output ser_valid,
        output done,
        output busy
    );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in serial-out shifter: takes a WIDTH-bit word, emits one bit per clock.
// Latency: first bit on ser_out one cycle after accept; frames stream back to back.
// Backpressure: load_ready only in idle or on the last frame bit; low during rst/preset.
//
// Ports: clk, rst (synchronous, active-high) as plain ports; everything else on
// bus (piso_serializer_if.slave): preset, load_valid/load_ready/load_data,
// ser_out, ser_valid, done, busy.
// MSB_FIRST selects bit order (0: bit 0 first, 1: bit WIDTH-1 first).
// Build option: define PISO_PARITY_EN to append an even-parity bit to each frame,
// making frames WIDTH+1 cycles long; the port list is the same in both builds.
module piso_serializer #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    piso_serializer_if.slave   bus
);
    localparam int CW = $clog2(WIDTH + 1);
`ifdef PISO_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif
    localparam logic [CW-1:0] LAST_IDX = CW'(FRAME - 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SHIFT = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
`ifdef PISO_PARITY_EN
    logic             parity_q, parity_d;
`endif

    logic in_shift;
    logic at_last;
    logic accept;
    logic head_bit;

    assign in_shift = (state_q == S_SHIFT);
    assign at_last  = in_shift && (cnt_q == LAST_IDX);

    // Ready in idle, or on the last bit so the next word follows without a gap.
    assign bus.load_ready = !rst && !bus.preset && (!in_shift || at_last);
    assign accept         = bus.load_valid && bus.load_ready;

    // The register shifts toward its output end, so the current bit is always
    // at a fixed position.
    assign head_bit = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];

`ifdef PISO_PARITY_EN
    // Once the data bits are exhausted the parity bit takes the output.
    assign bus.ser_out = in_shift &&
                         ((cnt_q == CW'(WIDTH)) ? parity_q : head_bit);
`else
    assign bus.ser_out = in_shift && head_bit;
`endif
    assign bus.ser_valid = in_shift;
    assign bus.done      = at_last;
    assign bus.busy      = in_shift;

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
`ifdef PISO_PARITY_EN
        parity_d = parity_q;
`endif
        if (bus.preset) begin
            state_d  = S_IDLE;
            shreg_d  = '1;
            cnt_d    = '0;
`ifdef PISO_PARITY_EN
            parity_d = 1'b0;
`endif
        end else if (accept) begin
            state_d  = S_SHIFT;
            shreg_d  = bus.load_data;
            cnt_d    = '0;
`ifdef PISO_PARITY_EN
            parity_d = ^bus.load_data;
`endif
        end else if (in_shift) begin
            if (at_last) begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
                if (MSB_FIRST) begin
                    shreg_d = {shreg_q[WIDTH-2:0], 1'b1};
                end else begin
                    shreg_d = {1'b1, shreg_q[WIDTH-1:1]};
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            shreg_q  <= '0;
            cnt_q    <= '0;
`ifdef PISO_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            cnt_q    <= cnt_d;
`ifdef PISO_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end
endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: an LSB-first and an MSB-first instance share stimulus.
// Reference: a queue of frame bits still to be shown; head is the current bit.
// Directed sequences first, then randomized load/preset/reset traffic.
module tb_piso_serializer;
    localparam int W = 4;
`ifdef PISO_PARITY_EN
    localparam int FRAME = W + 1;
`else
    localparam int FRAME = W;
`endif

    logic clk;
    logic rst;

    piso_serializer_if #(.WIDTH(W)) if_l ();
    piso_serializer_if #(.WIDTH(W)) if_m ();

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk (clk),
        .rst (rst),
        .bus (if_l)
    );

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clk (clk),
        .rst (rst),
        .bus (if_m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    // Pending frame bits; entry[1] = LSB-first bit, entry[0] = MSB-first bit.
    logic [1:0] pend[$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s act=%0h exp=%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic drive(input bit r, input bit p, input bit lv, input logic [W-1:0] d);
        rst             = r;
        if_l.preset     = p;
        if_m.preset     = p;
        if_l.load_valid = lv;
        if_m.load_valid = lv;
        if_l.load_data  = d;
        if_m.load_data  = d;
    endtask

    // One clock: drive inputs, check outputs against the queue, then advance the queue.
    task automatic cycle(input bit r, input bit p, input bit lv, input logic [W-1:0] d);
        logic       e_rdy;
        logic       e_vld;
        logic [1:0] head;
        logic       par;
        @(negedge clk);
        drive(r, p, lv, d);
        #1;
        e_vld = (pend.size() > 0);
        head  = e_vld ? pend[0] : 2'b00;
        e_rdy = !r && !p && (pend.size() <= 1);
        check("lsb.ser_valid",  32'(if_l.ser_valid),  32'(e_vld));
        check("lsb.ser_out",    32'(if_l.ser_out),    32'(head[1]));
        check("lsb.done",       32'(if_l.done),       32'(pend.size() == 1));
        check("lsb.busy",       32'(if_l.busy),       32'(e_vld));
        check("lsb.load_ready", 32'(if_l.load_ready), 32'(e_rdy));
        check("msb.ser_valid",  32'(if_m.ser_valid),  32'(e_vld));
        check("msb.ser_out",    32'(if_m.ser_out),    32'(head[0]));
        check("msb.done",       32'(if_m.done),       32'(pend.size() == 1));
        check("msb.busy",       32'(if_m.busy),       32'(e_vld));
        check("msb.load_ready", 32'(if_m.load_ready), 32'(e_rdy));
        @(posedge clk);
        if (r || p) begin
            pend.delete();
        end else begin
            if (pend.size() > 0) void'(pend.pop_front());
            if (lv && e_rdy) begin
                for (int k = 0; k < W; k++) pend.push_back({d[k], d[W-1-k]});
                if (FRAME > W) begin
                    par = ^d;
                    pend.push_back({par, par});
                end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 4'b0000);
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, 4'b0000);
        @(posedge clk);
        // Reset held, then released into idle.
        cycle(1'b1, 1'b0, 1'b0, 4'b0000);
        cycle(1'b1, 1'b0, 1'b0, 4'b0000);
        idle(3);
        // Single frame 1011.
        cycle(1'b0, 1'b0, 1'b1, 4'b1011);
        idle(6);
        // Back-to-back: 0001 then 1110 with load_valid held.
        cycle(1'b0, 1'b0, 1'b1, 4'b0001);
        for (int i = 0; i < FRAME; i++) cycle(1'b0, 1'b0, 1'b1, 4'b1110);
        idle(FRAME + 2);
        // Abort: load_valid while not ready on bits 0..1, preset on bit 2.
        cycle(1'b0, 1'b0, 1'b1, 4'b0110);
        cycle(1'b0, 1'b0, 1'b1, 4'b1001);
        cycle(1'b0, 1'b0, 1'b1, 4'b1001);
        cycle(1'b0, 1'b1, 1'b1, 4'b1001);
        idle(3);
        // Reset mid-frame.
        cycle(1'b0, 1'b0, 1'b1, 4'b1101);
        idle(2);
        cycle(1'b1, 1'b0, 1'b1, 4'b1111);
        idle(3);
        // Parity-sensitive words.
        cycle(1'b0, 1'b0, 1'b1, 4'b0111);
        idle(FRAME + 1);
        cycle(1'b0, 1'b0, 1'b1, 4'b0011);
        idle(FRAME + 1);
        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            cycle(($urandom_range(0, 99) < 2),
                  ($urandom_range(0, 99) < 3),
                  ($urandom_range(0, 99) < 65),
                  W'($urandom));
        end
        idle(FRAME + 2);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
Parallel-in serial-out shift register with a load handshake. It is the transmit-side counterpart of the team's serial-in parallel-out register. It accepts a WIDTH-bit word and presents it one bit per clock on a single serial line, qualified by a valid strobe. Bit order is selectable. A done pulse marks the last bit. Back-to-back words stream with no idle cycle between frames.

Parameters:
WIDTH, 4, data word width in bits (>= 2)
MSB_FIRST, 0, 0 = bit 0 shifted out first (matches the SIPO, where Q[0] is the first bit received); 1 = bit WIDTH-1 first

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  reset, synchronous, active-high
preset  in  1  synchronous abort; shift register forced to all ones
load_valid  in  1  load_data is valid this cycle
load_ready  out  1  block can accept a word this cycle
load_data  in  WIDTH  parallel word to serialize
ser_out  out  1  serial data bit
ser_valid  out  1  ser_out carries a frame bit this cycle
done  out  1  one-cycle pulse coincident with the last bit of a frame
busy  out  1  high while in state SHIFT

Behaviour:
- Reset (rst=1 at posedge) drives:
  - state=IDLE, shift register=0, bit counter=0
  - ser_out=0, ser_valid=0, done=0, busy=0
  - load_ready=1 (combinational; see below)
- Priority at each posedge: rst > preset > load/shift.
- States: IDLE and SHIFT.
- load_ready is combinational:
  - 1 in IDLE.
  - 1 in SHIFT only when the last frame bit is being presented (counter = FRAME-1).
  - 0 whenever rst or preset is high.
- Accept occurs when load_valid && load_ready at a posedge:
  - load_data is captured into the shift register.
  - The counter is cleared to 0 and the state becomes SHIFT.
- SHIFT output, with k = counter value:
  - ser_valid=1.
  - ser_out = data bit k (MSB_FIRST=0) or bit WIDTH-1-k (MSB_FIRST=1).
  - The value is registered, so the first bit appears the cycle after accept. Latency from accept to first bit is 1 cycle.
- Each SHIFT cycle the shift register shifts one place toward the output end (ones filled in) and the counter increments.
- FRAME = WIDTH bits (WIDTH+1 when the parity option is built in).
- done=1 exactly in the cycle ser_out shows bit FRAME-1.
- End of frame (counter = FRAME-1):
  - With an accept in that cycle: the new word loads and the first bit of the next frame follows in the very next cycle. No gap; ser_valid stays high.
  - Without an accept: the state returns to IDLE. The next cycle has ser_valid=0 and ser_out=0.
- IDLE holds ser_out=0, ser_valid=0, done=0.
- load_valid while load_ready=0 is ignored. The source must hold its data until the handshake completes.
- load_data is sampled only on accept. Changes to it mid-frame have no effect.
- preset=1 at a posedge, in any state:
  - state=IDLE, counter=0, shift register=all ones.
  - ser_valid=0, done=0, ser_out=0 on the next cycle.
  - Any in-flight frame is dropped without a done pulse, and no load is accepted that cycle.
- rst mid-frame: same as the reset values above. No done pulse.
- The counter width is clog2(WIDTH+1). It never wraps past FRAME-1.

Optional Feature:
Macro: PISO_PARITY_EN
- Defined:
  - Even parity (XOR of all WIDTH bits of the captured word) is computed at accept.
  - It is sent as an extra bit FRAME-1 = WIDTH after the data bits, so the frame is WIDTH+1 cycles.
  - done and the back-to-back load_ready window move to the parity cycle.
  - preset or rst drops the parity bit with the frame.
- Not defined:
  - No parity logic, frame of WIDTH cycles.
  - Port list is identical in both builds.

Test Plan:
- Reset then idle: hold rst=1 for 2 cycles, release -> ser_out=0, ser_valid=0, done=0, busy=0, load_ready=1 until a load arrives.
- Single LSB-first frame (WIDTH=4, MSB_FIRST=0): accept 4'b1011 -> on cycles +1..+4, ser_out=1,1,0,1 with ser_valid=1; done=1 only on +4; cycle +5 ser_valid=0, load_ready=1.
- MSB-first frame (MSB_FIRST=1): accept 4'b1011 -> ser_out=1,0,1,1 on cycles +1..+4.
- Back-to-back streaming: hold load_valid=1 with 4'b0001 then 4'b1110 (LSB-first) -> ser_out=1,0,0,0,0,1,1,1 over 8 consecutive cycles with ser_valid=1 throughout; done on cycles 4 and 8; load_ready=0 on cycles 1-3.
- Abort and backpressure: accept 4'b0110, assert preset on bit 2 -> next cycle IDLE, ser_valid=0, no done pulse; load_valid asserted on cycles 1-2 of a frame is not accepted; rst mid-frame gives the same reset values.
- Parity build (PISO_PARITY_EN, WIDTH=4): accept 4'b0111 -> ser_out=1,1,1,0 then parity bit 1 on cycle +5 with done; 4'b0011 -> parity bit 0.
